// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every N_IN-bit vector and compares a 1-bit DUT against EXPECTED.
// Latency: each vector is held DWELL cycles; busy lasts 2^N_IN*DWELL cycles; done rises the edge after the last sample.
// No backpressure: start is ignored while busy; results hold in DONE until the next start or rst.
module tt_sweep_checker #(
  parameter int N_IN = 4,
  parameter int DWELL = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 16'hF0F0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_f,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);

  // dwell_cnt needs at least one bit even when DWELL=1 (it then simply stays 0)
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_LAST   = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [DW-1:0] dwell_cnt;
  logic          sample;
  logic          miss;
  logic [N_IN:0] cnt_nxt;

  // Sample on the last dwell cycle of each vector; cnt_nxt lets pass reflect the final vector's result
  always_comb begin
    sample  = 1'b0;
    miss    = 1'b0;
    cnt_nxt = mismatch_cnt;
    if (state == RUN && dwell_cnt == DWELL_LAST) begin
      sample = 1'b1;
      miss   = (dut_f != EXPECTED[vec_out]);
    end
    cnt_nxt = mismatch_cnt + {{N_IN{1'b0}}, miss};
  end

  // Sweep FSM with all outputs registered; rst overrides every state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      vec_out      <= '0;
      dwell_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      fail_valid   <= 1'b0;
      first_fail   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            vec_out      <= '0;
            dwell_cnt    <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
          end
        end
        RUN: begin
          // start is deliberately not looked at here: a sweep always runs to completion
          if (sample) begin
            dwell_cnt    <= '0;
            mismatch_cnt <= cnt_nxt;
            if (miss && !fail_valid) begin
              first_fail <= vec_out;
              fail_valid <= 1'b1;
            end
            if (vec_out == VEC_LAST) begin
              state   <= DONE;
              vec_out <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (cnt_nxt == '0);
            end else begin
              vec_out <= vec_out + N_IN'(1);
            end
          end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

  localparam logic [15:0] GOLD = 16'hF0F0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: N_IN=4, DWELL=2, EXPECTED=16'hF0F0
  logic       start_a = 1'b0;
  logic [3:0] vec_a;
  logic       f_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic [4:0] cnt_a;
  logic [3:0] ff_a;
  int         mode_a = 0;

  // Instance B: N_IN=2, DWELL=1, EXPECTED=4'b0110
  logic       start_b = 1'b0;
  logic [1:0] vec_b;
  logic       f_b;
  logic       busy_b, done_b, pass_b, fv_b;
  logic [2:0] cnt_b;
  logic [1:0] ff_b;
  int         mode_b = 0;

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc;

  always #5 clk = ~clk;

  // DUT models: 0 golden, 1 stuck-at-0, 2 golden with vector 9 inverted
  always_comb begin
    f_a = 1'b0;
    case (mode_a)
      0: f_a = GOLD[vec_a];
      1: f_a = 1'b0;
      default: f_a = GOLD[vec_a] ^ (vec_a == 4'd9);
    endcase
  end

  // 0 = XOR DUT, 1 = OR DUT
  always_comb begin
    f_b = (mode_b == 0) ? (vec_b[1] ^ vec_b[0]) : (vec_b[1] | vec_b[0]);
  end

  tt_sweep_checker #(.N_IN(4), .DWELL(2), .EXPECTED(16'hF0F0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .dut_f(f_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_cnt(cnt_a),
    .fail_valid(fv_a), .first_fail(ff_a)
  );

  tt_sweep_checker #(.N_IN(2), .DWELL(1), .EXPECTED(4'b0110)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_b), .dut_f(f_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_cnt(cnt_b),
    .fail_valid(fv_b), .first_fail(ff_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_vec"}, 32'(vec_a), 0);
    chk({tag, "_busy"}, 32'(busy_a), 0);
    chk({tag, "_done"}, 32'(done_a), 0);
    chk({tag, "_pass"}, 32'(pass_a), 0);
    chk({tag, "_cnt"}, 32'(cnt_a), 0);
    chk({tag, "_fv"}, 32'(fv_a), 0);
    chk({tag, "_ff"}, 32'(ff_a), 0);
  endtask

  task automatic begin_sweep_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // Follows a running sweep until busy drops (bounded), checking the vector sequence.
  // restart_at: 1-based busy cycle on which start is pulsed again (-1 for none).
  task automatic run_rest_a(input int restart_at, output int n);
    n = 0;
    while (busy_a && n < 200) begin
      chk("vec_seq", 32'(vec_a), 32'(n / 2));
      n++;
      start_a = (n == restart_at);
      tick();
    end
    start_a = 1'b0;
  endtask

  task automatic chk_result_a(input string tag, input int pass_e, input int cnt_e,
                              input int fv_e, input int ff_e);
    chk({tag, "_busy"}, 32'(busy_a), 0);
    chk({tag, "_done"}, 32'(done_a), 1);
    chk({tag, "_pass"}, 32'(pass_a), 32'(pass_e));
    chk({tag, "_cnt"}, 32'(cnt_a), 32'(cnt_e));
    chk({tag, "_fv"}, 32'(fv_a), 32'(fv_e));
    if (fv_e != 0) chk({tag, "_ff"}, 32'(ff_a), 32'(ff_e));
    chk({tag, "_vec"}, 32'(vec_a), 0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    chk_reset_a("reset");
    chk("reset_b_busy", 32'(busy_b), 0);
    chk("reset_b_done", 32'(done_b), 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy_a), 0);

    // 1: golden DUT
    mode_a = 0;
    begin_sweep_a();
    chk("t1_start_busy", 32'(busy_a), 1);
    run_rest_a(-1, ncyc);
    chk("t1_busy_cycles", 32'(ncyc), 32);
    chk_result_a("t1", 1, 0, 0, 0);
    tick();
    tick();
    chk("t1_hold_done", 32'(done_a), 1);
    chk("t1_hold_pass", 32'(pass_a), 1);

    // 2: stuck-at-0 DUT
    mode_a = 1;
    begin_sweep_a();
    run_rest_a(-1, ncyc);
    chk("t2_busy_cycles", 32'(ncyc), 32);
    chk_result_a("t2", 0, 8, 1, 4);

    // 5: restart from DONE with golden DUT; results clear at the start edge
    mode_a = 0;
    begin_sweep_a();
    chk("t5_edge_busy", 32'(busy_a), 1);
    chk("t5_edge_done", 32'(done_a), 0);
    chk("t5_edge_pass", 32'(pass_a), 0);
    chk("t5_edge_cnt", 32'(cnt_a), 0);
    chk("t5_edge_fv", 32'(fv_a), 0);
    chk("t5_edge_ff", 32'(ff_a), 0);
    run_rest_a(-1, ncyc);
    chk("t5_busy_cycles", 32'(ncyc), 32);
    chk_result_a("t5", 1, 0, 0, 0);

    // 3: single inverted vector
    mode_a = 2;
    begin_sweep_a();
    run_rest_a(-1, ncyc);
    chk_result_a("t3", 0, 1, 1, 9);

    // 4a: start pulsed on RUN cycle 5 is ignored
    mode_a = 0;
    begin_sweep_a();
    run_rest_a(5, ncyc);
    chk("t4_restart_cycles", 32'(ncyc), 32);
    chk_result_a("t4a", 1, 0, 0, 0);

    // 4b: start coinciding with the last sample cycle is ignored; DONE still entered
    begin_sweep_a();
    run_rest_a(32, ncyc);
    chk("t4_last_cycles", 32'(ncyc), 32);
    chk_result_a("t4b", 1, 0, 0, 0);

    // 4c: rst on RUN cycle 10 aborts the sweep
    mode_a = 1;
    begin_sweep_a();
    for (int i = 1; i < 10; i++) tick();
    chk("t4_pre_rst_vec", 32'(vec_a), 4);
    chk("t4_pre_rst_cnt", 32'(cnt_a), 0);
    rst = 1'b1;
    tick();
    chk_reset_a("t4_rst");
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk_reset_a("t4_idle");

    // 6: N_IN=2, DWELL=1, XOR table with XOR DUT
    mode_b = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    ncyc = 0;
    while (busy_b && ncyc < 50) begin
      chk("t6_vec_seq", 32'(vec_b), 32'(ncyc));
      ncyc++;
      tick();
    end
    chk("t6_busy_cycles", 32'(ncyc), 4);
    chk("t6_done", 32'(done_b), 1);
    chk("t6_pass", 32'(pass_b), 1);
    chk("t6_cnt", 32'(cnt_b), 0);

    // 6: OR DUT differs only at vector 3
    mode_b = 1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    ncyc = 0;
    while (busy_b && ncyc < 50) begin
      ncyc++;
      tick();
    end
    chk("t6or_busy_cycles", 32'(ncyc), 4);
    chk("t6or_done", 32'(done_b), 1);
    chk("t6or_pass", 32'(pass_b), 0);
    chk("t6or_cnt", 32'(cnt_b), 1);
    chk("t6or_fv", 32'(fv_b), 1);
    chk("t6or_ff", 32'(ff_b), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
